uart_rx: RTL and testbench

Serial receive front end of the UART. It consumes the one-CLK-wide 16x-oversample strobe from the receive baud generator and deserialises 8N1 frames from the asynchronous RxD line. It presents each received byte on a single-entry valid/ready output register to the host-side logic and flags framing and overrun errors.

---
 rtl/uart_rx.sv | 133 +++++++++++++
 tb/tb_uart_rx.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x-oversampled deserialiser with a single-entry
// valid/ready holding register, framing-error pulse and sticky overrun flag.
module uart_rx (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SampleTick,
  input  logic       RxD,
  output logic [7:0] Data,
  output logic       Valid,
  input  logic       Ready,
  output logic       FrameErr,
  output logic       Overrun,
  output logic       Busy
);

  localparam int unsigned DataW = 8;
  localparam int unsigned TickW = 4;
  localparam int unsigned BitW  = 3;

  localparam logic [TickW-1:0] TickMid  = TickW'(7);
  localparam logic [TickW-1:0] TickLast = TickW'(15);
  localparam logic [BitW-1:0]  BitLast  = BitW'(DataW - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state;
  logic [1:0]         sync;
  logic               rx_s;
  logic [TickW-1:0]   tick_cnt;
  logic [BitW-1:0]    bit_cnt;
  logic [DataW-1:0]   shift;
  logic               done_ok;
  logic               done_err;

  assign rx_s = sync[1];

  // Two-flop synchroniser; resets to the idle (mark) level.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) sync <= 2'b11;
    else     sync <= {sync[0], RxD};
  end

  // Frame FSM; advances only on oversample ticks. done_* flag the stop sample.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      done_ok  <= 1'b0;
      done_err <= 1'b0;
      Busy     <= 1'b0;
    end else begin
      done_ok  <= 1'b0;
      done_err <= 1'b0;
      if (SampleTick) begin
        case (state)
          IDLE: begin
            if (!rx_s) begin
              state    <= START;
              tick_cnt <= '0;
              Busy     <= 1'b1;
            end
          end
          START: begin
            if (tick_cnt == TickMid) begin
              tick_cnt <= '0;
              if (!rx_s) begin
                state   <= DATA;
                bit_cnt <= '0;
              end else begin
                state <= IDLE;
                Busy  <= 1'b0;
              end
            end else begin
              tick_cnt <= tick_cnt + TickW'(1);
            end
          end
          DATA: begin
            if (tick_cnt == TickLast) begin
              tick_cnt <= '0;
              shift    <= {rx_s, shift[DataW-1:1]};
              if (bit_cnt == BitLast) state <= STOP;
              else                    bit_cnt <= bit_cnt + BitW'(1);
            end else begin
              tick_cnt <= tick_cnt + TickW'(1);
            end
          end
          STOP: begin
            if (tick_cnt == TickLast) begin
              tick_cnt <= '0;
              state    <= IDLE;
              Busy     <= 1'b0;
              done_ok  <= rx_s;
              done_err <= !rx_s;
            end else begin
              tick_cnt <= tick_cnt + TickW'(1);
            end
          end
          default: begin
            state <= IDLE;
            Busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Holding register and host handshake; runs every CLK.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Data     <= '0;
      Valid    <= 1'b0;
      FrameErr <= 1'b0;
      Overrun  <= 1'b0;
    end else begin
      FrameErr <= done_err;
      if (done_ok) begin
        if (!Valid || Ready) begin
          Data  <= shift;
          Valid <= 1'b1;
          if (Valid) Overrun <= 1'b0;
        end else begin
          Overrun <= 1'b1;
        end
      end else if (Valid && Ready) begin
        Valid   <= 1'b0;
        Overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random 8N1 frames
// compared against a frame-level reference model.
module tb_uart_rx;

  localparam int BIT_CLKS   = 64;
  localparam int FRAME_BUSY = 152 * 4;
  localparam int GLITCH_BUSY = 8 * 4;

  logic       CLK = 1'b0;
  logic       RST;
  logic       SampleTick;
  logic       RxD;
  logic       Ready;
  logic [7:0] Data;
  logic       Valid;
  logic       FrameErr;
  logic       Overrun;
  logic       Busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] obs_q[$];
  int         runs_q[$];
  int         fe_cnt;
  int         vh_cnt;

  uart_rx dut (
    .CLK       (CLK),
    .RST       (RST),
    .SampleTick(SampleTick),
    .RxD       (RxD),
    .Data      (Data),
    .Valid     (Valid),
    .Ready     (Ready),
    .FrameErr  (FrameErr),
    .Overrun   (Overrun),
    .Busy      (Busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Tick every 4 CLK.
  initial begin
    int tc;
    tc = 0;
    SampleTick = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      tc = (tc + 1) % 4;
      SampleTick = (tc == 0);
    end
  end

  // Observation: new bytes, FrameErr pulses, Busy run lengths, latencies.
  initial begin
    logic prev_valid, prev_ready, prev_fe;
    int   busy_run, idle_cnt;
    prev_valid = 0; prev_ready = 0; prev_fe = 0; busy_run = 0; idle_cnt = 0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        prev_valid = 0; prev_ready = 0; prev_fe = 0; busy_run = 0; idle_cnt = 0;
      end else begin
        if (Valid) vh_cnt++;
        if (Valid && !(prev_valid && !prev_ready)) begin
          obs_q.push_back(Data);
          check("valid_latency", idle_cnt, 1);
        end
        if (FrameErr) begin
          fe_cnt++;
          check("frameerr_width", {31'd0, prev_fe}, 0);
          check("frameerr_latency", idle_cnt, 1);
        end
        if (Busy) begin
          busy_run++;
          idle_cnt = 0;
        end else begin
          if (busy_run != 0) runs_q.push_back(busy_run);
          busy_run = 0;
          idle_cnt++;
        end
        prev_valid = Valid;
        prev_ready = Ready;
        prev_fe    = FrameErr;
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic hold_bit(input logic v);
    RxD = v;
    repeat (BIT_CLKS) @(posedge CLK);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    hold_bit(1'b0);
    for (int i = 0; i < 8; i++) hold_bit(b[i]);
    hold_bit(stop);
  endtask

  task automatic clear_obs();
    obs_q.delete();
    runs_q.delete();
    fe_cnt = 0;
    vh_cnt = 0;
  endtask

  task automatic cmp_phase(input string ph, input logic [7:0] eb[$], input int er[$], input int efe);
    check({ph, "_nbytes"}, obs_q.size(), eb.size());
    for (int i = 0; i < eb.size() && i < obs_q.size(); i++)
      check($sformatf("%s_byte%0d", ph, i), obs_q[i], eb[i]);
    check({ph, "_nruns"}, runs_q.size(), er.size());
    for (int i = 0; i < er.size() && i < runs_q.size(); i++)
      check($sformatf("%s_busyrun%0d", ph, i), runs_q[i], er[i]);
    check({ph, "_frameerr_cnt"}, fe_cnt, efe);
  endtask

  initial begin
    logic [7:0] eb[$];
    int         er[$];
    int         efe;
    logic [7:0] b;
    logic       stop;
    int         gap;

    RST = 1'b1; RxD = 1'b1; Ready = 1'b0;
    fe_cnt = 0; vh_cnt = 0;
    repeat (4) @(posedge CLK);
    #1;
    check("rst_data", Data, 0);
    check("rst_valid", Valid, 0);
    check("rst_frameerr", FrameErr, 0);
    check("rst_overrun", Overrun, 0);
    check("rst_busy", Busy, 0);
    @(negedge CLK) RST = 1'b0;
    @(posedge CLK); #1;
    hold_bit(1'b1);

    // 1: single frame, Ready held high.
    Ready = 1'b1;
    clear_obs();
    send_frame(8'h55, 1'b1);
    hold_bit(1'b1); hold_bit(1'b1);
    eb = '{8'h55}; er = '{FRAME_BUSY};
    cmp_phase("t1", eb, er, 0);
    check("t1_valid_cycles", vh_cnt, 1);
    check("t1_overrun", Overrun, 0);

    // 2: overrun with Ready low, then one-cycle handshake.
    Ready = 1'b0;
    clear_obs();
    send_frame(8'hA3, 1'b1);
    hold_bit(1'b1);
    check("t2_valid_first", Valid, 1);
    check("t2_data_first", Data, 8'hA3);
    check("t2_overrun_first", Overrun, 0);
    send_frame(8'h0F, 1'b1);
    hold_bit(1'b1); hold_bit(1'b1);
    check("t2_valid_held", Valid, 1);
    check("t2_data_held", Data, 8'hA3);
    check("t2_overrun_set", Overrun, 1);
    Ready = 1'b1;
    @(posedge CLK); #1;
    Ready = 1'b0;
    check("t2_valid_after_hs", Valid, 0);
    check("t2_overrun_after_hs", Overrun, 0);
    check("t2_data_after_hs", Data, 8'hA3);
    eb = '{8'hA3}; er = '{FRAME_BUSY, FRAME_BUSY};
    cmp_phase("t2", eb, er, 0);

    // 3: bad stop bit, then recovery.
    Ready = 1'b1;
    clear_obs();
    send_frame(8'hFF, 1'b0);
    hold_bit(1'b1);
    check("t3_valid_after_ferr", Valid, 0);
    send_frame(8'h12, 1'b1);
    hold_bit(1'b1); hold_bit(1'b1);
    eb = '{8'h12}; er = '{FRAME_BUSY, GLITCH_BUSY, FRAME_BUSY};
    cmp_phase("t3", eb, er, 1);

    // 4: short low glitch on the line.
    clear_obs();
    RxD = 1'b0;
    repeat (20) @(posedge CLK);
    #1;
    hold_bit(1'b1); hold_bit(1'b1);
    eb = '{}; er = '{GLITCH_BUSY};
    cmp_phase("t4", eb, er, 0);
    check("t4_valid_cycles", vh_cnt, 0);

    // 5: asynchronous reset mid-frame while a byte is held.
    Ready = 1'b0;
    clear_obs();
    send_frame(8'h5A, 1'b1);
    hold_bit(1'b1);
    check("t5_pre_valid", Valid, 1);
    b = 8'h3C;
    hold_bit(1'b0);
    for (int i = 0; i < 3; i++) hold_bit(b[i]);
    RxD = b[3];
    repeat (30) @(posedge CLK);
    check("t5_pre_busy", Busy, 1);
    #2 RST = 1'b1;
    #1;
    check("t5_rst_data", Data, 0);
    check("t5_rst_valid", Valid, 0);
    check("t5_rst_busy", Busy, 0);
    check("t5_rst_overrun", Overrun, 0);
    check("t5_rst_frameerr", FrameErr, 0);
    repeat (3) @(posedge CLK);
    RxD = 1'b1;
    @(negedge CLK) RST = 1'b0;
    @(posedge CLK); #1;
    hold_bit(1'b1);
    Ready = 1'b1;
    clear_obs();
    send_frame(8'hC3, 1'b1);
    hold_bit(1'b1); hold_bit(1'b1);
    eb = '{8'hC3}; er = '{FRAME_BUSY};
    cmp_phase("t5", eb, er, 0);
    check("t5_data_final", Data, 8'hC3);

    // 6: back-to-back frames with no idle gap.
    clear_obs();
    send_frame(8'h01, 1'b1);
    send_frame(8'h80, 1'b1);
    hold_bit(1'b1); hold_bit(1'b1);
    eb = '{8'h01, 8'h80}; er = '{FRAME_BUSY, FRAME_BUSY};
    cmp_phase("t6", eb, er, 0);

    // Random frames against a frame-level model.
    clear_obs();
    eb = '{}; er = '{}; efe = 0;
    for (int f = 0; f < 16; f++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      gap  = $urandom_range(0, 2);
      if (!stop && gap == 0) gap = 1;
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) @(posedge CLK);
        #1;
      end
      send_frame(b, stop);
      er.push_back(FRAME_BUSY);
      if (stop) begin
        eb.push_back(b);
      end else begin
        // Still-low stop bit retriggers start detection, rejected at mid-bit.
        er.push_back(GLITCH_BUSY);
        efe++;
      end
      repeat (gap) hold_bit(1'b1);
    end
    hold_bit(1'b1); hold_bit(1'b1);
    cmp_phase("rnd", eb, er, efe);
    check("rnd_overrun", Overrun, 0);
    check("rnd_valid_idle", Valid, 0);
    check("rnd_busy_idle", Busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
